// File: rtl/vx_alu_seq_if.sv
// vx_alu_seq_if: dispatch request, per-beat commit and branch-resolution bundle for the beat-sequenced ALU
interface vx_alu_seq_if #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int UUID_BITS   = 44,
  parameter int NW_BITS     = 2
);
  localparam int TIDW = NUM_THREADS > 1 ? $clog2(NUM_THREADS) : 1;
  localparam int PIDW = NUM_THREADS / NUM_LANES > 1 ? $clog2(NUM_THREADS / NUM_LANES) : 1;
  logic                        req_valid, req_ready;
  logic [UUID_BITS-1:0]        req_uuid;
  logic [NW_BITS-1:0]          req_wid;
  logic [NUM_THREADS-1:0]      req_tmask;
  logic [XLEN-1:0]             req_PC, req_next_PC, req_imm;
  logic [3:0]                  req_op;
  logic                        req_is_jal, req_use_PC, req_use_imm, req_wb;
  logic [4:0]                  req_rd;
  logic [TIDW-1:0]             req_tid;
  logic [NUM_THREADS*XLEN-1:0] req_rs1_data, req_rs2_data;
  logic                        commit_valid, commit_ready;
  logic [UUID_BITS-1:0]        commit_uuid;
  logic [NW_BITS-1:0]          commit_wid;
  logic [XLEN-1:0]             commit_PC;
  logic [4:0]                  commit_rd;
  logic                        commit_wb, commit_sop, commit_eop;
  logic [NUM_LANES-1:0]        commit_tmask;
  logic [PIDW-1:0]             commit_pid;
  logic [NUM_LANES*XLEN-1:0]   commit_data;
  logic                        br_valid, br_taken;
  logic [NW_BITS-1:0]          br_wid;
  logic [XLEN-1:0]             br_dest;
  modport master (
    output req_valid, req_uuid, req_wid, req_tmask, req_PC, req_next_PC, req_imm, req_op,
           req_is_jal, req_use_PC, req_use_imm, req_wb, req_rd, req_tid, req_rs1_data, req_rs2_data,
           commit_ready,
    input  req_ready, commit_valid, commit_uuid, commit_wid, commit_PC, commit_rd, commit_wb,
           commit_sop, commit_eop, commit_tmask, commit_pid, commit_data,
           br_valid, br_taken, br_wid, br_dest
  );
  modport slave (
    input  req_valid, req_uuid, req_wid, req_tmask, req_PC, req_next_PC, req_imm, req_op,
           req_is_jal, req_use_PC, req_use_imm, req_wb, req_rd, req_tid, req_rs1_data, req_rs2_data,
           commit_ready,
    output req_ready, commit_valid, commit_uuid, commit_wid, commit_PC, commit_rd, commit_wb,
           commit_sop, commit_eop, commit_tmask, commit_pid, commit_data,
           br_valid, br_taken, br_wid, br_dest
  );
endinterface

// File: rtl/vx_alu_seq.sv
// vx_alu_seq: warp ALU sequenced over NUM_LANES lanes in beats, LATENCY-deep stallable commit pipe; VX_ALU_SEQ_PERF_EN adds perf counters
module vx_alu_seq #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int LATENCY     = 1,
  parameter int UUID_BITS   = 44,
  parameter int NW_BITS     = 2
) (
  input  logic        clk,
  input  logic        reset,
  vx_alu_seq_if.slave bus
`ifdef VX_ALU_SEQ_PERF_EN
  ,
  output logic [63:0] perf_beats,
  output logic [63:0] perf_stalls,
  output logic [63:0] perf_skips
`endif
);
  localparam int NB = NUM_THREADS / NUM_LANES;
  localparam int PIDW = NB > 1 ? $clog2(NB) : 1;
  localparam int SW = $clog2(XLEN);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEQ = 1'b1;
  typedef struct packed {
    logic [UUID_BITS-1:0]        uuid;
    logic [NW_BITS-1:0]          wid;
    logic [NUM_THREADS-1:0]      tmask;
    logic [XLEN-1:0]             pc, npc, imm;
    logic [3:0]                  op;
    logic                        jal, use_pc, use_imm, wb;
    logic [4:0]                  rd;
    logic [NUM_THREADS*XLEN-1:0] rs1, rs2;
    logic                        br, taken;
    logic [XLEN-1:0]             dest;
  } req_t;
  typedef struct packed {
    logic [UUID_BITS-1:0]      uuid;
    logic [NW_BITS-1:0]        wid;
    logic [XLEN-1:0]           pc;
    logic [4:0]                rd;
    logic                      wb;
    logic [NUM_LANES-1:0]      tmask;
    logic [PIDW-1:0]           pid;
    logic [NUM_LANES*XLEN-1:0] data;
    logic                      sop, eop, br, taken;
    logic [XLEN-1:0]           dest;
  } beat_t;
  logic [0:0]         state;
  logic [NB-1:0]      rem, act, cand, left;
  logic [PIDW-1:0]    pick;
  req_t               q, in, cur;
  beat_t              nb;
  beat_t              pipe [LATENCY];
  logic [LATENCY-1:0] v;
  logic               idle, adv, issue, cmp;
  logic [XLEN-1:0]    br_a, br_b, a, b, r;
  logic [XLEN:0]      ds, du;
  assign idle = state == IDLE;
  assign adv = ~(v[LATENCY-1] & ~bus.commit_ready);
  assign bus.req_ready = reset & idle & adv;
  assign issue = idle ? bus.req_valid & bus.req_ready : adv;
  // capture the incoming request and resolve its branch once from thread req_tid
  always_comb begin
    in = '0;
    in.uuid = bus.req_uuid;
    in.wid = bus.req_wid;
    in.tmask = bus.req_tmask;
    in.pc = bus.req_PC;
    in.npc = bus.req_next_PC;
    in.imm = bus.req_imm;
    in.op = bus.req_op;
    in.jal = bus.req_is_jal;
    in.use_pc = bus.req_use_PC;
    in.use_imm = bus.req_use_imm;
    in.wb = bus.req_wb;
    in.rd = bus.req_rd;
    in.rs1 = bus.req_rs1_data;
    in.rs2 = bus.req_rs2_data;
    br_a = bus.req_rs1_data[bus.req_tid*XLEN +: XLEN];
    br_b = bus.req_rs2_data[bus.req_tid*XLEN +: XLEN];
    cmp = bus.req_op == 4'd10 ? br_a == br_b :
          bus.req_op == 4'd11 ? br_a != br_b :
          bus.req_op == 4'd12 ? $signed(br_a) < $signed(br_b) :
          bus.req_op == 4'd13 ? $signed(br_a) >= $signed(br_b) :
          bus.req_op == 4'd14 ? br_a < br_b : br_a >= br_b;
    in.br = bus.req_is_jal | bus.req_op >= 4'd10;
    in.taken = bus.req_is_jal | (bus.req_op >= 4'd10 & cmp);
    in.dest = ((bus.req_use_PC ? bus.req_PC : br_a) + bus.req_imm) & ~XLEN'(bus.req_is_jal & ~bus.req_use_PC);
  end
  // choose the lowest pending non-empty beat and compute its lane results
  always_comb begin
    cur = idle ? in : q;
    for (int p = 0; p < NB; p++) act[p] = |bus.req_tmask[p*NUM_LANES +: NUM_LANES];
    cand = idle ? act : rem;
    pick = '0;
    for (int p = NB - 1; p >= 0; p--) if (cand[p]) pick = PIDW'(p);
    left = cand & ~(NB'(1) << pick);
    nb = '0;
    nb.uuid = cur.uuid;
    nb.wid = cur.wid;
    nb.pc = cur.pc;
    nb.rd = cur.rd;
    nb.wb = cur.wb;
    nb.tmask = cur.tmask[pick*NUM_LANES +: NUM_LANES];
    nb.pid = pick;
    nb.sop = idle;
    nb.eop = left == '0;
    nb.br = cur.br & nb.eop;
    nb.taken = cur.taken;
    nb.dest = cur.dest;
    {a, b, r, ds, du} = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      a = cur.use_pc ? cur.pc : cur.rs1[(pick*NUM_LANES+l)*XLEN +: XLEN];
      b = cur.use_imm ? cur.imm : cur.rs2[(pick*NUM_LANES+l)*XLEN +: XLEN];
      ds = {a[XLEN-1], a} - {b[XLEN-1], b};
      du = {1'b0, a} - {1'b0, b};
      case (cur.op)
        4'd0:    r = a + b;
        4'd1:    r = a - b;
        4'd2:    r = XLEN'(ds[XLEN]);
        4'd3:    r = XLEN'(du[XLEN]);
        4'd4:    r = a & b;
        4'd5:    r = a | b;
        4'd6:    r = a ^ b;
        4'd7:    r = a << b[SW-1:0];
        4'd8:    r = a >> b[SW-1:0];
        4'd9:    r = $signed(a) >>> b[SW-1:0];
        default: r = '0;
      endcase
      nb.data[l*XLEN +: XLEN] = cur.jal ? cur.npc : r;
    end
  end
  // sequencer: latch the request on accept and track beats still to issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rem <= '0;
      q <= '0;
    end else if (issue) begin
      if (idle) q <= in;
      rem <= left;
      state <= left != '0 ? SEQ : IDLE;
    end
  end
  // result pipeline; every stage holds while the commit beat is stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= '0;
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else if (adv) begin
      v[0] <= issue;
      pipe[0] <= nb;
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        pipe[i] <= pipe[i-1];
      end
    end
  end
  assign bus.commit_valid = v[LATENCY-1];
  assign bus.commit_uuid = pipe[LATENCY-1].uuid;
  assign bus.commit_wid = pipe[LATENCY-1].wid;
  assign bus.commit_PC = pipe[LATENCY-1].pc;
  assign bus.commit_rd = pipe[LATENCY-1].rd;
  assign bus.commit_wb = pipe[LATENCY-1].wb;
  assign bus.commit_tmask = pipe[LATENCY-1].tmask;
  assign bus.commit_pid = pipe[LATENCY-1].pid;
  assign bus.commit_data = pipe[LATENCY-1].data;
  assign bus.commit_sop = pipe[LATENCY-1].sop;
  assign bus.commit_eop = pipe[LATENCY-1].eop;
  assign bus.br_valid = bus.commit_valid & bus.commit_ready & pipe[LATENCY-1].br;
  assign bus.br_taken = pipe[LATENCY-1].taken;
  assign bus.br_wid = pipe[LATENCY-1].wid;
  assign bus.br_dest = pipe[LATENCY-1].dest;
`ifdef VX_ALU_SEQ_PERF_EN
  logic [63:0] skips;
  assign skips = 64'(NB) - 64'($countones(act)) - 64'(act == '0);
  // committed beats, stalled cycles and empty beats skipped at accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_beats <= '0;
      perf_stalls <= '0;
      perf_skips <= '0;
    end else begin
      if (bus.commit_valid & bus.commit_ready) perf_beats <= perf_beats + 64'd1;
      if (bus.commit_valid & ~bus.commit_ready) perf_stalls <= perf_stalls + 64'd1;
      if (idle & issue) perf_skips <= perf_skips + skips;
    end
  end
`endif
endmodule
